fwd_hazard: RTL and testbench

Parametrised forwarding and load-use hazard unit for the 5-stage pipe, the next generation of the decode-stage bypass selector. It tracks destination metadata for instructions in E, M and W in its own stage registers. It resolves NUM_SRC decode source operands through an E > M > W priority bypass and raises a one-cycle load-use stall. It also handles flush bubbles, never forwards into x0, and keeps a saturating stall counter.

---
 rtl/fwd_hazard.sv | 106 ++++++++++
 tb/tb_fwd_hazard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard.sv
// Decode-stage bypass selector and load-use hazard detector for the 5-stage pipe.
// Tracks destination metadata for E/M/W and resolves NUM_SRC operands with E > M > W priority.
module fwd_hazard #(
  parameter int XLEN      = 64,
  parameter int REG_WIDTH = 5,
  parameter int NUM_SRC   = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         d_valid_i,
  input  logic                         d_wen_i,
  input  logic                         d_is_load_i,
  input  logic [REG_WIDTH-1:0]         d_dst_i,
  input  logic [NUM_SRC*REG_WIDTH-1:0] d_src_i,
  input  logic [NUM_SRC-1:0]           d_src_used_i,
  input  logic [NUM_SRC*XLEN-1:0]      d_rval_i,
  input  logic [XLEN-1:0]              e_valE_i,
  input  logic [XLEN-1:0]              M_valE_i,
  input  logic [XLEN-1:0]              m_valM_i,
  input  logic [XLEN-1:0]              W_val_i,
  input  logic                         flush_i,
  output logic [NUM_SRC*XLEN-1:0]      d_val_o,
  output logic                         stall_o,
  output logic [CNT_WIDTH-1:0]         stall_cnt_o
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic                 e_vld, m_vld, w_vld;
  logic [REG_WIDTH-1:0] e_dst, m_dst, w_dst;
  logic                 e_ld, m_ld, w_ld;
  logic [NUM_SRC-1:0]   hz;
  logic                 e_bubble;

  // Decode: per-source bypass mux and load-use detection
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_WIDTH-1:0] s;
    logic                 s_nz;
    logic [XLEN-1:0]      val;

    assign s    = d_src_i[k*REG_WIDTH +: REG_WIDTH];
    assign s_nz = (s != '0);

    always_comb begin
      val = d_rval_i[k*XLEN +: XLEN];
      if (!s_nz)
        val = '0;
      else if (e_vld && e_dst == s && !e_ld)
        val = e_valE_i;
      else if (m_vld && m_dst == s)
        val = m_ld ? m_valM_i : M_valE_i;
      else if (w_vld && w_dst == s)
        val = W_val_i;
    end

    assign d_val_o[k*XLEN +: XLEN] = val;
    assign hz[k] = d_src_used_i[k] && s_nz && e_vld && e_ld && (e_dst == s);
  end

  // Flush overrides a hazard: the killed instruction must not hold the front end.
  assign stall_o  = d_valid_i && !flush_i && (|hz);
  assign e_bubble = flush_i || stall_o || !d_valid_i;

  // E/M/W stage registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e_vld <= 1'b0;
      e_dst <= '0;
      e_ld  <= 1'b0;
      m_vld <= 1'b0;
      m_dst <= '0;
      m_ld  <= 1'b0;
      w_vld <= 1'b0;
      w_dst <= '0;
      w_ld  <= 1'b0;
    end else begin
      w_vld <= m_vld;
      w_dst <= m_dst;
      w_ld  <= m_ld;
      m_vld <= e_vld;
      m_dst <= e_dst;
      m_ld  <= e_ld;
      if (e_bubble) begin
        e_vld <= 1'b0;
        e_dst <= '0;
        e_ld  <= 1'b0;
      end else begin
        e_vld <= d_wen_i && (d_dst_i != '0);
        e_dst <= d_dst_i;
        e_ld  <= d_is_load_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      stall_cnt_o <= '0;
    else if (stall_o)
      stall_cnt_o <= sat_inc(stall_cnt_o);
  end

endmodule

// File: tb/tb_fwd_hazard.sv
// Directed bench for fwd_hazard: bypass priority, load-use stall, flush, x0, reset and counter saturation.
module tb_fwd_hazard;
  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int NS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             d_valid, d_wen, d_is_load, flush;
  logic [RW-1:0]    d_dst;
  logic [NS*RW-1:0] d_src;
  logic [NS-1:0]    d_used;
  logic [NS*XLEN-1:0] d_rval;
  logic [XLEN-1:0]  e_valE, M_valE, m_valM, W_val;
  logic [NS*XLEN-1:0] d_val, d_val2;
  logic             stall, stall2;
  logic [31:0]      cnt;
  logic [1:0]       cnt2;

  int tests = 0;
  int fails = 0;

  fwd_hazard #(.XLEN(XLEN), .REG_WIDTH(RW), .NUM_SRC(NS), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_wen_i(d_wen),
    .d_is_load_i(d_is_load), .d_dst_i(d_dst), .d_src_i(d_src), .d_src_used_i(d_used),
    .d_rval_i(d_rval), .e_valE_i(e_valE), .M_valE_i(M_valE), .m_valM_i(m_valM),
    .W_val_i(W_val), .flush_i(flush), .d_val_o(d_val), .stall_o(stall), .stall_cnt_o(cnt)
  );

  fwd_hazard #(.XLEN(XLEN), .REG_WIDTH(RW), .NUM_SRC(NS), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid), .d_wen_i(d_wen),
    .d_is_load_i(d_is_load), .d_dst_i(d_dst), .d_src_i(d_src), .d_src_used_i(d_used),
    .d_rval_i(d_rval), .e_valE_i(e_valE), .M_valE_i(M_valE), .m_valM_i(m_valM),
    .W_val_i(W_val), .flush_i(flush), .d_val_o(d_val2), .stall_o(stall2), .stall_cnt_o(cnt2)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic ld, input logic [RW-1:0] dst,
                       input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [NS-1:0] used);
    d_valid   = v;
    d_wen     = wen;
    d_is_load = ld;
    d_dst     = dst;
    d_src     = {s1, s0};
    d_used    = used;
    flush     = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    d_rval = {64'h2222, 64'h1111};
    e_valE = 64'h0; M_valE = 64'h0; m_valM = 64'h0; W_val = 64'h0;
    drive(1, 0, 0, 0, 5, 0, 2'b01);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_cnt", {32'd0, cnt}, 64'd0);
    chk("reset_dval0_raw", d_val[63:0], 64'h1111);
    chk("reset_dval1_x0", d_val[127:64], 64'h0);
    tick(); tick();
    rst_n = 1'b1;

    // ALU chain: add x5 then use x5
    drive(1, 1, 0, 5, 0, 0, 2'b00);
    tick();
    e_valE = 64'h11;
    drive(1, 0, 0, 0, 5, 0, 2'b01);
    chk("alu_fwd_E", d_val[63:0], 64'h11);
    chk("alu_no_stall", {63'd0, stall}, 64'd0);
    tick();
    e_valE = 64'h99; M_valE = 64'h11;
    drive(1, 0, 0, 0, 5, 0, 2'b01);
    chk("alu_fwd_M", d_val[63:0], 64'h11);
    tick();

    // Load-use: load x7 then use x7
    drive(1, 1, 1, 7, 0, 0, 2'b00);
    tick();
    m_valM = 64'hDEAD; e_valE = 64'h55;
    drive(1, 0, 0, 0, 7, 0, 2'b01);
    chk("lu_stall", {63'd0, stall}, 64'd1);
    chk("lu_cnt_before", {32'd0, cnt}, 64'd0);
    tick();
    chk("lu_stall_released", {63'd0, stall}, 64'd0);
    chk("lu_fwd_load", d_val[63:0], 64'hDEAD);
    chk("lu_cnt_after", {32'd0, cnt}, 64'd1);
    tick();

    // Priority: three writers of x3 occupy W, M, E
    drive(1, 1, 0, 3, 0, 0, 2'b00); tick();
    drive(1, 1, 0, 3, 0, 0, 2'b00); tick();
    drive(1, 1, 0, 3, 0, 0, 2'b00); tick();
    W_val = 64'hA; M_valE = 64'hB; e_valE = 64'hC;
    drive(1, 1, 1, 3, 3, 3, 2'b01);
    chk("prio_E_src0", d_val[63:0], 64'hC);
    chk("prio_E_src1", d_val[127:64], 64'hC);
    chk("prio_no_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(1, 0, 0, 0, 3, 0, 2'b00);
    chk("prio_Eload_falls_to_M", d_val[63:0], 64'hB);
    chk("prio_unused_no_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(1, 0, 0, 0, 3, 0, 2'b00);
    chk("prio_M_load_data", d_val[63:0], 64'hDEAD);
    tick();
    drive(1, 0, 0, 0, 3, 0, 2'b00);
    chk("prio_W", d_val[63:0], 64'hA);
    tick();

    // x0 writes and reads never forward
    drive(1, 1, 0, 0, 0, 0, 2'b00);
    tick();
    e_valE = 64'h77;
    drive(1, 0, 0, 0, 0, 0, 2'b11);
    chk("x0_src0", d_val[63:0], 64'h0);
    chk("x0_src1", d_val[127:64], 64'h0);
    drive(1, 1, 1, 9, 0, 0, 2'b00);
    tick();
    drive(1, 0, 0, 0, 9, 0, 2'b10);
    chk("unused_src_no_stall", {63'd0, stall}, 64'd0);
    chk("unused_src_raw", d_val[63:0], 64'h1111);

    // Flush coincident with a load-use hazard
    drive(1, 1, 0, 4, 9, 0, 2'b01);
    flush = 1'b1;
    #1;
    chk("flush_no_stall", {63'd0, stall}, 64'd0);
    tick();
    chk("flush_cnt_hold", {32'd0, cnt}, 64'd1);
    e_valE = 64'h44;
    drive(1, 0, 0, 0, 4, 9, 2'b01);
    chk("flush_bubble_no_E_fwd", d_val[63:0], 64'h1111);
    chk("flush_load_in_M", d_val[127:64], 64'hDEAD);
    chk("flush_after_no_stall", {63'd0, stall}, 64'd0);
    tick();

    // Reset asserted mid-stall
    drive(1, 1, 1, 7, 0, 0, 2'b00);
    tick();
    drive(1, 0, 0, 0, 7, 0, 2'b01);
    chk("rst_pre_stall", {63'd0, stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall_drop", {63'd0, stall}, 64'd0);
    chk("rst_mid_cnt", {32'd0, cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 7, 0, 2'b01);
    chk("rst_after_raw", d_val[63:0], 64'h1111);
    chk("rst_after_no_stall", {63'd0, stall}, 64'd0);
    tick();

    // Four load-use stalls: 32-bit counter reaches 4, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 7, 0, 0, 2'b00);
      tick();
      drive(1, 0, 0, 0, 7, 0, 2'b01);
      chk("sat_loop_stall", {63'd0, stall}, 64'd1);
      chk("sat_loop_stall_w2", {63'd0, stall2}, 64'd1);
      tick();
      chk("sat_loop_single_bubble", {63'd0, stall}, 64'd0);
      tick();
    end
    chk("sat_cnt32", {32'd0, cnt}, 64'd4);
    chk("sat_cnt2", {62'd0, cnt2}, 64'd3);
    chk("sat_w2_dval", d_val2[63:0], d_val[63:0] ^ 64'h0 | 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
